// File: rtl/nf_io_stack_mux_if.sv
// Multi-lane AXI-Stream bundle used on both the region side (N lanes) and the
// stack side (one lane) of the I/O-stack adapter.
interface nf_io_stack_mux_if #(
    parameter int unsigned N_LANES   = 1,
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned ID_BITS   = 1
);
    logic [N_LANES-1:0]                  tvalid;
    logic [N_LANES-1:0]                  tready;
    logic [N_LANES-1:0]                  tlast;
    logic [N_LANES-1:0][DATA_BITS-1:0]   tdata;
    logic [N_LANES-1:0][DATA_BITS/8-1:0] tkeep;
    logic [N_LANES-1:0][ID_BITS-1:0]     tid;

    modport master (
        output tvalid,
        input  tready,
        output tlast,
        output tdata,
        output tkeep,
        output tid
    );

    modport slave (
        input  tvalid,
        output tready,
        input  tlast,
        input  tdata,
        input  tkeep,
        input  tid
    );
endinterface

// File: rtl/nf_io_stack_mux.sv
// I/O-stack side adapter: per-packet round-robin merge of region streams onto the stack TX
// stream (tagged by tid), and tid-based steering of stack RX back to regions with drop.
module nf_io_stack_mux #(
    parameter int unsigned N_REGIONS = 4,
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned RID_BITS  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    nf_io_stack_mux_if.slave         io_src,
    nf_io_stack_mux_if.master        stack_tx,
    nf_io_stack_mux_if.slave         stack_rx,
    nf_io_stack_mux_if.master        io_sink,
    output logic [31:0]              rx_drop_cnt
);

    localparam int unsigned KEEP_BITS = DATA_BITS / 8;

    function automatic logic [RID_BITS-1:0] wrap_add(input logic [RID_BITS-1:0] base,
                                                     input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_REGIONS) begin
            sum = sum - N_REGIONS;
        end
        return RID_BITS'(sum);
    endfunction

    // ------------------------------------------------------------------
    // TX arbiter and output register
    // ------------------------------------------------------------------
    logic [RID_BITS-1:0]    rr_ptr_q, rr_ptr_d;
    logic                   locked_q, locked_d;
    logic [RID_BITS-1:0]    lock_id_q, lock_id_d;
    logic [RID_BITS-1:0]    grant;
    logic                   found;
    logic [2*N_REGIONS-1:0] vld_dbl;
    logic [N_REGIONS-1:0]   vld_rot;
    logic                   tx_ready;
    logic                   tx_accept;

    logic                   tx_valid_q, tx_valid_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic [KEEP_BITS-1:0]   tx_keep_q, tx_keep_d;
    logic                   tx_last_q, tx_last_d;
    logic [RID_BITS-1:0]    tx_tid_q, tx_tid_d;

    // Rotate valids so that bit 0 corresponds to rr_ptr; first set bit wins.
    always_comb begin
        vld_dbl = {io_src.tvalid, io_src.tvalid};
        vld_rot = N_REGIONS'(vld_dbl >> rr_ptr_q);
        found   = 1'b0;
        grant   = locked_q ? lock_id_q : rr_ptr_q;
        if (!locked_q) begin
            for (int unsigned i = 0; i < N_REGIONS; i++) begin
                if (!found && vld_rot[i]) begin
                    grant = wrap_add(rr_ptr_q, i);
                    found = 1'b1;
                end
            end
        end
    end

    assign tx_ready  = !tx_valid_q || stack_tx.tready[0];
    assign tx_accept = io_src.tvalid[grant] && tx_ready;

    always_comb begin
        io_src.tready        = '0;
        io_src.tready[grant] = tx_ready;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        locked_d   = locked_q;
        lock_id_d  = lock_id_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_keep_d  = tx_keep_q;
        tx_last_d  = tx_last_q;
        tx_tid_d   = tx_tid_q;
        if (tx_accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = io_src.tdata[grant];
            tx_keep_d  = io_src.tkeep[grant];
            tx_last_d  = io_src.tlast[grant];
            tx_tid_d   = grant;
            if (io_src.tlast[grant]) begin
                rr_ptr_d = wrap_add(grant, 1);
                locked_d = 1'b0;
            end else begin
                locked_d  = 1'b1;
                lock_id_d = grant;
            end
        end else if (stack_tx.tready[0]) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr_q   <= '0;
            locked_q   <= 1'b0;
            lock_id_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_keep_q  <= '0;
            tx_last_q  <= 1'b0;
            tx_tid_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            locked_q   <= locked_d;
            lock_id_q  <= lock_id_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_keep_q  <= tx_keep_d;
            tx_last_q  <= tx_last_d;
            tx_tid_q   <= tx_tid_d;
        end
    end

    assign stack_tx.tvalid = tx_valid_q;
    assign stack_tx.tdata  = tx_data_q;
    assign stack_tx.tkeep  = tx_keep_q;
    assign stack_tx.tlast  = tx_last_q;
    assign stack_tx.tid    = tx_tid_q;

    // Region-side tid carries nothing on the TX path; the tag is the grant.
    logic unused_src_tid;
    assign unused_src_tid = ^io_src.tid;

    // ------------------------------------------------------------------
    // RX steering
    // ------------------------------------------------------------------
    logic                 rx_in_pkt_q, rx_in_pkt_d;
    logic [RID_BITS-1:0]  rx_sel_q, rx_sel_d;
    logic                 rx_drop_q, rx_drop_d;
    logic [RID_BITS-1:0]  cur_sel;
    logic                 cur_drop;
    logic                 rx_beat;
    logic                 sink_ready;

    logic                 out_valid_q, out_valid_d;
    logic [RID_BITS-1:0]  out_sel_q, out_sel_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic [KEEP_BITS-1:0] out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;
    logic [31:0]          drop_cnt_q, drop_cnt_d;

    // Routing is decided on the first beat; later tid values are ignored.
    assign cur_sel  = rx_in_pkt_q ? rx_sel_q  : stack_rx.tid[0];
    assign cur_drop = rx_in_pkt_q ? rx_drop_q : (32'(stack_rx.tid[0]) >= N_REGIONS);

    assign sink_ready        = io_sink.tready[out_sel_q];
    assign stack_rx.tready   = cur_drop || !out_valid_q || sink_ready;
    assign rx_beat           = stack_rx.tvalid[0] && stack_rx.tready[0];

    always_comb begin
        rx_in_pkt_d = rx_in_pkt_q;
        rx_sel_d    = rx_sel_q;
        rx_drop_d   = rx_drop_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        drop_cnt_d  = drop_cnt_q;
        if (rx_beat) begin
            rx_in_pkt_d = !stack_rx.tlast[0];
            rx_sel_d    = cur_sel;
            rx_drop_d   = cur_drop;
            if (cur_drop && stack_rx.tlast[0] && (drop_cnt_q != 32'hFFFF_FFFF)) begin
                drop_cnt_d = drop_cnt_q + 32'd1;
            end
        end
        if (rx_beat && !cur_drop) begin
            out_valid_d = 1'b1;
            out_sel_d   = cur_sel;
            out_data_d  = stack_rx.tdata[0];
            out_keep_d  = stack_rx.tkeep[0];
            out_last_d  = stack_rx.tlast[0];
        end else if (sink_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_in_pkt_q <= 1'b0;
            rx_sel_q    <= '0;
            rx_drop_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rx_in_pkt_q <= rx_in_pkt_d;
            rx_sel_q    <= rx_sel_d;
            rx_drop_q   <= rx_drop_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        io_sink.tvalid = '0;
        for (int unsigned i = 0; i < N_REGIONS; i++) begin
            io_sink.tvalid[i] = out_valid_q && (out_sel_q == RID_BITS'(i));
        end
    end

    assign io_sink.tdata = {N_REGIONS{out_data_q}};
    assign io_sink.tkeep = {N_REGIONS{out_keep_q}};
    assign io_sink.tlast = {N_REGIONS{out_last_q}};
    assign io_sink.tid   = {N_REGIONS{out_sel_q}};
    assign rx_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_nf_io_stack_mux.sv
// Directed bench for nf_io_stack_mux: a 4-region instance for TX/RX behaviour and a
// 3-region instance for the out-of-range tid drop path.
module tb_nf_io_stack_mux;

    logic        aclk;
    logic        aresetn;
    logic [31:0] drop4;
    logic [31:0] drop3;

    nf_io_stack_mux_if #(.N_LANES(4), .DATA_BITS(32), .ID_BITS(2)) src4 ();
    nf_io_stack_mux_if #(.N_LANES(4), .DATA_BITS(32), .ID_BITS(2)) sink4 ();
    nf_io_stack_mux_if #(.N_LANES(1), .DATA_BITS(32), .ID_BITS(2)) tx4 ();
    nf_io_stack_mux_if #(.N_LANES(1), .DATA_BITS(32), .ID_BITS(2)) rx4 ();

    nf_io_stack_mux_if #(.N_LANES(3), .DATA_BITS(32), .ID_BITS(2)) src3 ();
    nf_io_stack_mux_if #(.N_LANES(3), .DATA_BITS(32), .ID_BITS(2)) sink3 ();
    nf_io_stack_mux_if #(.N_LANES(1), .DATA_BITS(32), .ID_BITS(2)) tx3 ();
    nf_io_stack_mux_if #(.N_LANES(1), .DATA_BITS(32), .ID_BITS(2)) rx3 ();

    nf_io_stack_mux #(.N_REGIONS(4), .DATA_BITS(32)) dut4 (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .io_src      (src4),
        .stack_tx    (tx4),
        .stack_rx    (rx4),
        .io_sink     (sink4),
        .rx_drop_cnt (drop4)
    );

    nf_io_stack_mux #(.N_REGIONS(3), .DATA_BITS(32)) dut3 (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .io_src      (src3),
        .stack_tx    (tx3),
        .stack_rx    (rx3),
        .io_sink     (sink3),
        .rx_drop_cnt (drop3)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_vec;
    int          n_err;
    int          beat[4];
    int          b1;
    int          idx;
    int          cyc;
    logic        got0;
    logic [3:0]  rdy;
    logic [3:0]  vld;
    logic [31:0] exp_lk[5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_all();
        src4.tvalid = '0; src4.tlast = '0; src4.tdata = '0; src4.tkeep = '0; src4.tid = '0;
        src3.tvalid = '0; src3.tlast = '0; src3.tdata = '0; src3.tkeep = '0; src3.tid = '0;
        rx4.tvalid  = '0; rx4.tlast  = '0; rx4.tdata  = '0; rx4.tkeep  = '0; rx4.tid  = '0;
        rx3.tvalid  = '0; rx3.tlast  = '0; rx3.tdata  = '0; rx3.tkeep  = '0; rx3.tid  = '0;
        tx4.tready  = 1'b1;
        tx3.tready  = 1'b1;
        sink4.tready = 4'hF;
        sink3.tready = 3'h7;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        aresetn = 1'b0;
        idle_all();
        #12;
        chk("rst_tx_valid", tx4.tvalid, 0);
        chk("rst_sink_valid", sink4.tvalid, 0);
        chk("rst_drop_cnt", drop4, 0);
        chk("rst_rr_ptr", dut4.rr_ptr_q, 0);
        aresetn = 1'b1;
        tick();

        // Round-robin: four 2-beat packets, expect regions 0..3 back to back.
        for (int r = 0; r < 4; r++) beat[r] = 0;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 4; r++) begin
                src4.tvalid[r] = (beat[r] < 2);
                src4.tdata[r]  = 32'(16 * r + beat[r]);
                src4.tlast[r]  = (beat[r] == 1);
                src4.tkeep[r]  = 4'(1 << r);
            end
            #1;
            rdy = src4.tready;
            vld = src4.tvalid;
            tick();
            for (int r = 0; r < 4; r++) if (rdy[r] && vld[r]) beat[r]++;
            chk("rr_valid", tx4.tvalid, 1);
            chk("rr_tid", tx4.tid[0], k / 2);
            chk("rr_data", tx4.tdata[0], 16 * (k / 2) + k % 2);
            chk("rr_last", tx4.tlast, k % 2);
            chk("rr_keep", tx4.tkeep[0], 1 << (k / 2));
        end
        src4.tvalid = '0;
        chk("rr_ptr_wrap", dut4.rr_ptr_q, 0);
        tick();
        chk("rr_drained", tx4.tvalid, 0);

        // Packet lock under toggling backpressure: region 1 (4 beats) then region 0.
        exp_lk = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h55};
        b1   = 0;
        got0 = 1'b0;
        idx  = 0;
        cyc  = 0;
        while (idx < 5 && cyc < 40) begin
            src4.tvalid[1] = (b1 < 4);
            src4.tdata[1]  = 32'(32'h20 + b1);
            src4.tlast[1]  = (b1 == 3);
            src4.tvalid[0] = (cyc > 0) && !got0;
            src4.tdata[0]  = 32'h55;
            src4.tlast[0]  = 1'b1;
            tx4.tready     = (cyc % 2 == 0);
            #1;
            if (b1 < 4 && cyc > 0) chk("lock_r0_blocked", src4.tready[0], 0);
            if (tx4.tvalid[0] && tx4.tready[0]) begin
                chk("lock_order", tx4.tdata[0], exp_lk[idx]);
                idx++;
            end
            rdy = src4.tready;
            vld = src4.tvalid;
            tick();
            if (rdy[1] && vld[1]) b1++;
            if (rdy[0] && vld[0]) got0 = 1'b1;
            cyc++;
        end
        chk("lock_all_beats", idx, 5);
        idle_all();
        tick();

        // Single 3-beat packet from region 2.
        for (int b = 0; b < 3; b++) begin
            src4.tvalid[2] = 1'b1;
            src4.tdata[2]  = 32'(32'hA + b);
            src4.tlast[2]  = (b == 2);
            #1;
            chk("sp_ready", src4.tready[2], 1);
            tick();
            chk("sp_valid", tx4.tvalid, 1);
            chk("sp_data", tx4.tdata[0], 32'hA + b);
            chk("sp_tid", tx4.tid[0], 2);
            chk("sp_last", tx4.tlast, (b == 2));
        end
        src4.tvalid = '0;
        tick();
        chk("sp_idle", tx4.tvalid, 0);
        chk("sp_rr_ptr", dut4.rr_ptr_q, 3);

        // RX steering: tid 3 two beats with a 5-cycle sink stall, then tid 0 one beat.
        sink4.tready = 4'b0111;
        rx4.tvalid   = 1'b1;
        rx4.tid[0]   = 2'd3;
        rx4.tdata[0] = 32'h31;
        rx4.tkeep[0] = 4'h3;
        rx4.tlast    = 1'b0;
        #1;
        chk("rx_ready_first", rx4.tready, 1);
        chk("rx_sink_idle", sink4.tvalid, 0);
        tick();
        rx4.tdata[0] = 32'h32;
        rx4.tlast    = 1'b1;
        rx4.tid[0]   = 2'd1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("rx_stall_valid", sink4.tvalid, 4'b1000);
            chk("rx_stall_data", sink4.tdata[3], 32'h31);
            chk("rx_stall_ready", rx4.tready, 0);
            tick();
        end
        chk("rx_keep", sink4.tkeep[3], 4'h3);
        sink4.tready = 4'hF;
        #1;
        chk("rx_resume_ready", rx4.tready, 1);
        tick();
        rx4.tid[0]   = 2'd0;
        rx4.tdata[0] = 32'h01;
        rx4.tlast    = 1'b1;
        #1;
        chk("rx_b2_valid", sink4.tvalid, 4'b1000);
        chk("rx_b2_data", sink4.tdata[3], 32'h32);
        chk("rx_b2_last", sink4.tlast[3], 1);
        chk("rx_b2_ready", rx4.tready, 1);
        tick();
        rx4.tvalid = 1'b0;
        #1;
        chk("rx_t0_valid", sink4.tvalid, 4'b0001);
        chk("rx_t0_data", sink4.tdata[0], 32'h01);
        tick();
        chk("rx_drained", sink4.tvalid, 0);

        // RX drop on the 3-region instance: tid 3 names no region.
        chk("drop_cnt_before", drop3, 0);
        rx3.tvalid = 1'b1;
        rx3.tid[0] = 2'd3;
        for (int b = 0; b < 4; b++) begin
            rx3.tdata[0] = 32'(32'h40 + b);
            rx3.tlast    = (b == 3);
            #1;
            chk("drop_ready", rx3.tready, 1);
            chk("drop_no_sink", sink3.tvalid, 0);
            tick();
            chk("drop_no_sink_after", sink3.tvalid, 0);
        end
        rx3.tid[0]   = 2'd2;
        rx3.tdata[0] = 32'h99;
        rx3.tlast    = 1'b1;
        #1;
        chk("drop_cnt_after", drop3, 1);
        tick();
        rx3.tvalid = 1'b0;
        #1;
        chk("drop_then_keep", sink3.tvalid, 3'b100);
        chk("drop_then_data", sink3.tdata[2], 32'h99);
        chk("drop_cnt_stable", drop3, 1);
        tick();

        // Reset mid-packet on TX.
        src4.tvalid[0] = 1'b1;
        src4.tdata[0]  = 32'h60;
        src4.tlast[0]  = 1'b0;
        tick();
        src4.tdata[0]  = 32'h61;
        #1;
        chk("pre_rst_valid", tx4.tvalid, 1);
        chk("pre_rst_locked", dut4.locked_q, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tx_valid", tx4.tvalid, 0);
        chk("mid_rst_sink_valid", sink4.tvalid, 0);
        chk("mid_rst_rr_ptr", dut4.rr_ptr_q, 0);
        chk("mid_rst_locked", dut4.locked_q, 0);
        chk("mid_rst_drop3", drop3, 0);
        idle_all();
        tick();
        aresetn = 1'b1;
        src4.tvalid[1] = 1'b1;
        src4.tdata[1]  = 32'h77;
        src4.tlast[1]  = 1'b1;
        src4.tvalid[3] = 1'b1;
        src4.tdata[3]  = 32'h33;
        src4.tlast[3]  = 1'b1;
        #1;
        chk("post_rst_r1_ready", src4.tready[1], 1);
        chk("post_rst_r3_wait", src4.tready[3], 0);
        tick();
        chk("post_rst_valid", tx4.tvalid, 1);
        chk("post_rst_tid", tx4.tid[0], 1);
        chk("post_rst_data", tx4.tdata[0], 32'h77);
        src4.tvalid[1] = 1'b0;
        #1;
        chk("post_rst_r3_ready", src4.tready[3], 1);
        tick();
        chk("post_rst_r3_tid", tx4.tid[0], 3);
        chk("post_rst_r3_data", tx4.tdata[0], 32'h33);
        idle_all();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
